// File: rtl/decode_queue_if.sv
`default_nettype none
// decode_queue_if: fetch-side, EX-side and load-use signals of decode_queue (rev 1.0).
// master = environment (fetch/EX), slave = decode_queue.
interface decode_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            flush;
  logic            idex_mem_rd;
  logic [4:0]      idex_rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [3:0]      out_funct;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;
  logic            hazard;
  logic [CW-1:0]   count;

  modport master (
    output in_valid, in_pc, in_instr, flush, idex_mem_rd, idex_rd, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_funct, out_rs1, out_rs2,
           out_rd, out_imm, out_illegal, hazard, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, idex_mem_rd, idex_rd, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_funct, out_rs1, out_rs2,
           out_rd, out_imm, out_illegal, hazard, count
  );
endinterface
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// decode_queue: instruction FIFO feeding an RV32I decode register with load-use stall (rev 1.0).
// Option DQ_FALLTHROUGH_EN: an instruction arriving at an empty queue decodes straight into the output register.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic          clk,
  input  logic          rst,
  decode_queue_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            r_or_v;
  logic [XLEN-1:0] r_pc;
  logic [6:0]      r_opcode;
  logic [3:0]      r_funct;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_imm;
  logic            r_illegal;

  logic            w_full;
  logic            w_empty;
  logic            w_hazard;
  logic            w_out_valid;
  logic            w_transfer;
  logic            w_or_free;
  logic            w_push_req;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;
  logic            w_or_load;
  logic [XLEN-1:0] w_src_pc;
  logic [31:0]     w_src_instr;

  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_d_imm;
  logic [4:0]      w_d_rd;
  logic            w_d_illegal;

  // ---------------------------------------------------------------
  // Handshake and queue control
  // ---------------------------------------------------------------
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_hazard    = r_or_v && bus.idex_mem_rd && (bus.idex_rd != 5'd0) &&
                       ((bus.idex_rd == r_rs1) || (bus.idex_rd == r_rs2));
  assign w_out_valid = r_or_v && !w_hazard;
  assign w_transfer  = w_out_valid && bus.out_ready;
  // A stalled OR is never free because w_transfer already excludes hazard.
  assign w_or_free   = !r_or_v || w_transfer;
  assign w_push_req  = bus.in_valid && !w_full && !bus.flush;

`ifdef DQ_FALLTHROUGH_EN
  assign w_bypass    = w_push_req && w_empty && w_or_free;
`else
  assign w_bypass    = 1'b0;
`endif

  assign w_push      = w_push_req && !w_bypass;
  assign w_pop       = !w_empty && w_or_free;
  assign w_or_load   = w_pop || w_bypass;
  assign w_src_pc    = w_bypass ? bus.in_pc    : pc_mem[r_rd_ptr];
  assign w_src_instr = w_bypass ? bus.in_instr : instr_mem[r_rd_ptr];

  // ---------------------------------------------------------------
  // Immediate / destination decode of the selected source
  // ---------------------------------------------------------------
  always_comb begin
    w_imm32     = '1;
    w_d_illegal = 1'b0;
    w_d_rd      = w_src_instr[11:7];
    case (w_src_instr[6:0])
      OP_LUI, OP_AUIPC:
        w_imm32 = {w_src_instr[31:12], 12'b0};
      OP_JAL:
        w_imm32 = {{12{w_src_instr[31]}}, w_src_instr[19:12], w_src_instr[20],
                   w_src_instr[30:21], 1'b0};
      // fence and system are RV32I base opcodes and carry an I-type field
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM:
        w_imm32 = {{20{w_src_instr[31]}}, w_src_instr[31:20]};
      OP_BRANCH: begin
        w_imm32 = {{20{w_src_instr[31]}}, w_src_instr[7], w_src_instr[30:25],
                   w_src_instr[11:8], 1'b0};
        w_d_rd  = 5'd0;
      end
      OP_STORE: begin
        w_imm32 = {{20{w_src_instr[31]}}, w_src_instr[31:25], w_src_instr[11:7]};
        w_d_rd  = 5'd0;
      end
      OP_REG:
        w_imm32 = '0;
      default: begin
        w_imm32     = '1;
        w_d_illegal = 1'b1;
      end
    endcase
    w_d_imm = XLEN'($signed(w_imm32));
  end

  // ---------------------------------------------------------------
  // Queue storage (not reset; only pointers define occupancy)
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      pc_mem[r_wr_ptr]    <= bus.in_pc;
      instr_mem[r_wr_ptr] <= bus.in_instr;
    end
  end

  // ---------------------------------------------------------------
  // Pointers, occupancy and output register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_or_v    <= 1'b0;
      r_pc      <= '0;
      r_opcode  <= '0;
      r_funct   <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_imm     <= '0;
      r_illegal <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_or_v   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end

      if (w_or_load) begin
        r_or_v    <= 1'b1;
        r_pc      <= w_src_pc;
        r_opcode  <= w_src_instr[6:0];
        r_funct   <= {w_src_instr[30], w_src_instr[14:12]};
        r_rs1     <= w_src_instr[19:15];
        r_rs2     <= w_src_instr[24:20];
        r_rd      <= w_d_rd;
        r_imm     <= w_d_imm;
        r_illegal <= w_d_illegal;
      end else if (w_transfer) begin
        r_or_v <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  assign bus.in_ready    = bus.flush || !w_full;
  assign bus.out_valid   = w_out_valid;
  assign bus.hazard      = w_hazard;
  assign bus.count       = r_count;
  assign bus.out_pc      = r_pc;
  assign bus.out_opcode  = r_opcode;
  assign bus.out_funct   = r_funct;
  assign bus.out_rs1     = r_rs1;
  assign bus.out_rs2     = r_rs2;
  assign bus.out_rd      = r_rd;
  assign bus.out_imm     = r_imm;
  assign bus.out_illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// tb_decode_queue: directed self-checking bench for decode_queue (DEPTH=4, XLEN=32), rev 1.0.
module tb_decode_queue;

`ifdef DQ_FALLTHROUGH_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  localparam logic [31:0] ADD_X3_X1_X2 = 32'h002081B3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  decode_queue_if #(.DEPTH(4), .XLEN(32)) bus ();

  decode_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.in_pc       = '0;
    bus.in_instr    = '0;
    bus.flush       = 1'b0;
    bus.idex_mem_rd = 1'b0;
    bus.idex_rd     = '0;
    bus.out_ready   = 1'b0;
  endtask

  function automatic logic [31:0] addi(input int v);
    logic [11:0] imm;
    logic [4:0]  rd;
    imm = 12'(v);
    rd  = 5'(v);
    return {imm, 5'd0, 3'd0, rd, 7'h13};
  endfunction

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0 || bus.hazard !== 1'b0) begin errors++; $display("FAIL reset_valid_hazard: got %b%b expected 00", bus.out_valid, bus.hazard); end
    checks++; if (bus.out_pc !== 32'h0 || bus.out_imm !== 32'h0 || bus.out_illegal !== 1'b0 || bus.out_rd !== 5'd0) begin
      errors++; $display("FAIL reset_data: got pc=%h imm=%h ill=%b rd=%0d expected zeros", bus.out_pc, bus.out_imm, bus.out_illegal, bus.out_rd);
    end
  endtask

  task automatic test_fill();
    idle();
    for (int k = 0; k < 6; k++) begin
      bus.in_valid = 1'b1;
      bus.in_pc    = 32'h100 + 32'(4 * k);
      bus.in_instr = addi(k + 1);
      if (k == 5) begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", bus.count); end
        checks++; if (bus.out_pc !== 32'h100 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL fill_or: got pc=%h v=%b expected pc=100 v=1", bus.out_pc, bus.out_valid); end
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 + 32'(4 * k) || bus.out_imm !== 32'(k + 1)) begin
        errors++; $display("FAIL fill_drain_%0d: got v=%b pc=%h imm=%h expected v=1 pc=%h imm=%h",
                           k, bus.out_valid, bus.out_pc, bus.out_imm, 32'h100 + 32'(4 * k), 32'(k + 1));
      end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL fill_empty: got v=%b count=%0d expected v=0 count=0", bus.out_valid, bus.count); end
  endtask

  task automatic test_hazard();
    idle();
    bus.out_ready   = 1'b1;
    bus.idex_mem_rd = 1'b1;
    bus.idex_rd     = 5'd2;
    bus.in_valid    = 1'b1;
    bus.in_pc       = 32'h200;
    bus.in_instr    = ADD_X3_X1_X2;
    tick();
    bus.in_valid = 1'b0;
    for (int w = 0; w < 5 && bus.hazard !== 1'b1; w++) tick();
    checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL hazard_start: got %b expected 1", bus.hazard); end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.hazard !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL hazard_hold_%0d: got hazard=%b v=%b expected hazard=1 v=0", c, bus.hazard, bus.out_valid);
      end
      tick();
    end
    bus.idex_mem_rd = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 || bus.out_rs1 !== 5'd1 || bus.out_rs2 !== 5'd2 ||
        bus.out_rd !== 5'd3 || bus.out_opcode !== 7'h33 || bus.out_imm !== 32'h0 || bus.hazard !== 1'b0) begin
      errors++; $display("FAIL hazard_release: got v=%b pc=%h rs1=%0d rs2=%0d rd=%0d op=%h imm=%h expected v=1 pc=200 rs1=1 rs2=2 rd=3 op=33 imm=0",
                         bus.out_valid, bus.out_pc, bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_opcode, bus.out_imm);
    end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hazard_single: got v=%b expected 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    idle();
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_pc    = 32'h300 + 32'(4 * k);
      bus.in_instr = addi(k + 1);
      tick();
    end
    checks++; if (bus.count !== 3'd3 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre: got count=%0d v=%b expected count=3 v=1", bus.count, bus.out_valid); end
    bus.flush    = 1'b1;
    bus.in_pc    = 32'h3F0;
    bus.in_instr = addi(7);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready); end
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_post: got count=%0d v=%b expected count=0 v=0", bus.count, bus.out_valid); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped_%0d: got v=%b pc=%h expected v=0", c, bus.out_valid, bus.out_pc); end
    end
  endtask

  task automatic test_decode();
    logic [31:0] v_instr [7];
    logic [31:0] v_imm   [7];
    logic [4:0]  v_rd    [7];
    logic        v_ill   [7];
    int          got;
    v_instr = '{32'hFE000EE3, 32'h00100093, 32'hFFFFFFFF, 32'h00000000, 32'h0020A423, 32'h123452B7, 32'hFF9FF0EF};
    v_imm   = '{32'hFFFFFFFC, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000008, 32'h12345000, 32'hFFFFFFF8};
    v_rd    = '{5'd0, 5'd1, 5'd31, 5'd0, 5'd0, 5'd5, 5'd1};
    v_ill   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    got = 0;
    idle();
    bus.out_ready = 1'b1;
    for (int t = 0; t < 14; t++) begin
      bus.in_valid = (t < 7);
      bus.in_pc    = 32'h400 + 32'(4 * t);
      bus.in_instr = (t < 7) ? v_instr[t] : 32'h0;
      tick();
      if (bus.out_valid === 1'b1 && got < 7) begin
        checks++;
        if (bus.out_pc !== 32'h400 + 32'(4 * got) || bus.out_imm !== v_imm[got] ||
            bus.out_rd !== v_rd[got] || bus.out_illegal !== v_ill[got]) begin
          errors++; $display("FAIL decode_%0d: got pc=%h imm=%h rd=%0d ill=%b expected pc=%h imm=%h rd=%0d ill=%b",
                             got, bus.out_pc, bus.out_imm, bus.out_rd, bus.out_illegal,
                             32'h400 + 32'(4 * got), v_imm[got], v_rd[got], v_ill[got]);
        end
        got++;
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (got != 7) begin errors++; $display("FAIL decode_count: got %0d expected 7", got); end
  endtask

  task automatic test_back_to_back();
    int got;
    got = 0;
    idle();
    bus.out_ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      bus.in_valid = (t < 9);
      bus.in_pc    = 32'h600 + 32'(4 * t);
      bus.in_instr = addi(t + 1);
      if (t < 9) begin
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_%0d: got %b expected 1", t, bus.in_ready); end
      end
      tick();
      if (bus.out_valid === 1'b1 && got < 9) begin
        checks++;
        if (t != LAT - 1 + got || bus.out_pc !== 32'h600 + 32'(4 * got) || bus.out_imm !== 32'(got + 1)) begin
          errors++; $display("FAIL b2b_%0d: got cycle=%0d pc=%h imm=%h expected cycle=%0d pc=%h imm=%h",
                             got, t, bus.out_pc, bus.out_imm, LAT - 1 + got, 32'h600 + 32'(4 * got), 32'(got + 1));
        end
        got++;
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (got != 9) begin errors++; $display("FAIL b2b_count: got %0d expected 9", got); end
  endtask

  task automatic test_reset_mid();
    idle();
    bus.idex_mem_rd = 1'b1;
    bus.idex_rd     = 5'd1;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_pc    = 32'h700 + 32'(4 * k);
      bus.in_instr = ADD_X3_X1_X2;
      tick();
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.count !== 3'd3 || bus.hazard !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got count=%0d hazard=%b expected count=3 hazard=1", bus.count, bus.hazard); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.count !== 3'd0 || bus.hazard !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.out_pc !== 32'h0 || bus.out_imm !== 32'h0 || bus.out_rd !== 5'd0 || bus.out_rs1 !== 5'd0 || bus.out_illegal !== 1'b0) begin
      errors++; $display("FAIL rstmid_post: got count=%0d hazard=%b v=%b rdy=%b pc=%h imm=%h rd=%0d rs1=%0d ill=%b expected zeros with rdy=1",
                         bus.count, bus.hazard, bus.out_valid, bus.in_ready, bus.out_pc, bus.out_imm, bus.out_rd, bus.out_rs1, bus.out_illegal);
    end
    bus.idex_mem_rd = 1'b0;
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_pc       = 32'h800;
    bus.in_instr    = addi(5);
    tick();
    bus.in_valid = 1'b0;
    for (int w = 0; w < 5 && bus.out_valid !== 1'b1; w++) tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h800 || bus.out_imm !== 32'h5) begin
      errors++; $display("FAIL rstmid_fresh: got v=%b pc=%h imm=%h expected v=1 pc=800 imm=5", bus.out_valid, bus.out_pc, bus.out_imm);
    end
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_hazard();
    test_flush();
    test_decode();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
